mult_control_n: RTL and testbench

- Parametrised successor to the fixed 8x8 sequential multiplier controller.
- Sequences an A_SLICES x B_SLICES nibble-slice multiply through one shared 4x4 multiplier, shifter and accumulator.
- Counts partial products internally; no external count input.
- Adds busy/done handshake, error reporting and a restart path from any non-busy state.

---
 rtl/mult_control_n.sv | 142 ++++++++++++++
 tb/tb_mult_control_n.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_control_n.sv
// Controller for an A_SLICES x B_SLICES nibble-slice multiply sequenced
// through one shared 4x4 multiplier, shifter and accumulator.
// Adds a busy/done handshake, abort-to-error reporting and restart from any
// non-busy state.
module mult_control_n #(
    parameter int unsigned A_SLICES = 2,
    parameter int unsigned B_SLICES = 2,
    localparam int unsigned AW  = (A_SLICES > 1) ? $clog2(A_SLICES) : 1,
    localparam int unsigned BW  = (B_SLICES > 1) ? $clog2(B_SLICES) : 1,
    localparam int unsigned SW  = ((A_SLICES + B_SLICES - 1) > 1) ?
                                  $clog2(A_SLICES + B_SLICES - 1) : 1,
    localparam int unsigned NPP = A_SLICES * B_SLICES
) (
    input  logic          clk,
    input  logic          reset_a,
    input  logic          start,
    output logic [AW-1:0] a_sel,
    output logic [BW-1:0] b_sel,
    output logic [SW-1:0] shift_sel,
    output logic [2:0]    state_out,
    output logic          clk_ena,
    output logic          sclr_n,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CALC   = 3'd1,
        S_FINISH = 3'd2,
        S_ERR    = 3'd3
    } state_t;

    localparam logic [AW-1:0] I_LAST = AW'(A_SLICES - 1);
    localparam logic [BW-1:0] J_LAST = BW'(B_SLICES - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] i_q, i_d;
    logic [BW-1:0] j_q, j_d;
    logic          accept;
    logic          i_wrap;
    logic          last_pp;

    // Start is masked while reset is held so the Mealy outputs stay at reset values.
    assign accept  = start && !reset_a;
    assign i_wrap  = (i_q == I_LAST);
    assign last_pp = i_wrap && (j_q == J_LAST);
    assign state_out = 3'(state_q);

    // State and slice-counter registers.
    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            state_q <= S_IDLE;
            i_q     <= AW'(0);
            j_q     <= BW'(0);
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    // Next-state, counter stepping and output decode.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        a_sel     = AW'(0);
        b_sel     = BW'(0);
        shift_sel = SW'(0);
        clk_ena   = 1'b0;
        sclr_n    = 1'b1;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_CALC;
                    i_d     = AW'(0);
                    j_d     = BW'(0);
                    clk_ena = 1'b1;
                    sclr_n  = 1'b0;
                end
            end

            S_CALC: begin
                busy      = 1'b1;
                clk_ena   = 1'b1;
                a_sel     = i_q;
                b_sel     = j_q;
                shift_sel = SW'(i_q) + SW'(j_q);
                if (start) begin
                    // Abort: the current product still loads, the result is void.
                    state_d = S_ERR;
                    i_d     = AW'(0);
                    j_d     = BW'(0);
                end else if (last_pp) begin
                    state_d = S_FINISH;
                    i_d     = AW'(0);
                    j_d     = BW'(0);
                end else if (i_wrap) begin
                    i_d = AW'(0);
                    j_d = BW'(j_q + BW'(1));
                end else begin
                    i_d = AW'(i_q + AW'(1));
                end
            end

            S_FINISH: begin
                done = 1'b1;
                if (accept) begin
                    state_d = S_CALC;
                    i_d     = AW'(0);
                    j_d     = BW'(0);
                    clk_ena = 1'b1;
                    sclr_n  = 1'b0;
                end
            end

            S_ERR: begin
                err = 1'b1;
                if (accept) begin
                    state_d = S_CALC;
                    i_d     = AW'(0);
                    j_d     = BW'(0);
                    clk_ena = 1'b1;
                    sclr_n  = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
                i_d     = AW'(0);
                j_d     = BW'(0);
            end
        endcase
    end

endmodule

// File: tb/tb_mult_control_n.sv
// Bench for mult_control_n: 2x2, 4x2 and 1x1 instances; stimulus pushes the
// expected per-cycle outputs into a queue, a monitor pops and compares.
module tb_mult_control_n;

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] sh;
        logic       ce;
        logic       sc;
        logic       busy;
        logic       done;
        logic       err;
    } obs_t;

    logic clk;
    logic rst;
    logic start2, start4, start1;
    logic end_req;

    // 2x2 instance
    logic [0:0] a2, b2;
    logic [1:0] sh2;
    logic [2:0] st2;
    logic ce2, sc2, bz2, dn2, er2;
    // 4x2 instance
    logic [1:0] a4;
    logic [0:0] b4;
    logic [2:0] sh4;
    logic [2:0] st4;
    logic ce4, sc4, bz4, dn4, er4;
    // 1x1 instance
    logic [0:0] a1, b1;
    logic [0:0] sh1;
    logic [2:0] st1;
    logic ce1, sc1, bz1, dn1, er1;

    obs_t obs2, obs4, obs1;
    obs_t q2[$];
    obs_t q4[$];
    obs_t q1[$];

    int checks = 0;
    int errors = 0;

    int A2[4] = '{0, 1, 0, 1};
    int B2[4] = '{0, 0, 1, 1};
    int S2[4] = '{0, 1, 1, 2};
    int A4[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int B4[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    int S4[8] = '{0, 1, 2, 3, 1, 2, 3, 4};

    mult_control_n #(.A_SLICES(2), .B_SLICES(2)) u_d2 (
        .clk(clk), .reset_a(rst), .start(start2),
        .a_sel(a2), .b_sel(b2), .shift_sel(sh2), .state_out(st2),
        .clk_ena(ce2), .sclr_n(sc2), .busy(bz2), .done(dn2), .err(er2)
    );

    mult_control_n #(.A_SLICES(4), .B_SLICES(2)) u_d4 (
        .clk(clk), .reset_a(rst), .start(start4),
        .a_sel(a4), .b_sel(b4), .shift_sel(sh4), .state_out(st4),
        .clk_ena(ce4), .sclr_n(sc4), .busy(bz4), .done(dn4), .err(er4)
    );

    mult_control_n #(.A_SLICES(1), .B_SLICES(1)) u_d1 (
        .clk(clk), .reset_a(rst), .start(start1),
        .a_sel(a1), .b_sel(b1), .shift_sel(sh1), .state_out(st1),
        .clk_ena(ce1), .sclr_n(sc1), .busy(bz1), .done(dn1), .err(er1)
    );

    assign obs2 = {st2, 4'(a2), 4'(b2), 5'(sh2), ce2, sc2, bz2, dn2, er2};
    assign obs4 = {st4, 4'(a4), 4'(b4), 5'(sh4), ce4, sc4, bz4, dn4, er4};
    assign obs1 = {st1, 4'(a1), 4'(b1), 5'(sh1), ce1, sc1, bz1, dn1, er1};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected-output builder; busy/done/err follow the state code.
    function automatic obs_t ex(input int st, input int a, input int b, input int sh,
                                input logic ce, input logic sc);
        obs_t o;
        o.st   = 3'(st);
        o.a    = 4'(a);
        o.b    = 4'(b);
        o.sh   = 5'(sh);
        o.ce   = ce;
        o.sc   = sc;
        o.busy = (st == 1);
        o.done = (st == 2);
        o.err  = (st == 3);
        return o;
    endfunction

    function automatic obs_t idle_e();   return ex(0, 0, 0, 0, 1'b0, 1'b1); endfunction
    function automatic obs_t acc_idle(); return ex(0, 0, 0, 0, 1'b1, 1'b0); endfunction
    function automatic obs_t fin_e();    return ex(2, 0, 0, 0, 1'b0, 1'b1); endfunction
    function automatic obs_t acc_fin();  return ex(2, 0, 0, 0, 1'b1, 1'b0); endfunction
    function automatic obs_t err_e();    return ex(3, 0, 0, 0, 1'b0, 1'b1); endfunction
    function automatic obs_t acc_err();  return ex(3, 0, 0, 0, 1'b1, 1'b0); endfunction

    task automatic chk(input string name, input obs_t act, input obs_t exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s t=%0t act st=%0d a=%0d b=%0d sh=%0d ce=%b sc=%b busy=%b done=%b err=%b exp st=%0d a=%0d b=%0d sh=%0d ce=%b sc=%b busy=%b done=%b err=%b",
                     name, $time, act.st, act.a, act.b, act.sh, act.ce, act.sc, act.busy,
                     act.done, act.err, exp_v.st, exp_v.a, exp_v.b, exp_v.sh, exp_v.ce,
                     exp_v.sc, exp_v.busy, exp_v.done, exp_v.err);
        end
    endtask

    // Monitor: compares mid-cycle, then closes the run on request.
    always @(negedge clk) begin
        if (q2.size() > 0) chk("d2x2", obs2, q2.pop_front());
        if (q4.size() > 0) chk("d4x2", obs4, q4.pop_front());
        if (q1.size() > 0) chk("d1x1", obs1, q1.pop_front());
        if (end_req) begin
            checks++;
            if (q2.size() + q4.size() + q1.size() != 0) begin
                errors++;
                $display("FAIL leftover act=%0d exp=0", q2.size() + q4.size() + q1.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    // One cycle: set start for an instance and record the outputs it must show.
    task automatic drive(input int d, input logic s, input obs_t e);
        @(posedge clk);
        #1;
        case (d)
            2: begin start2 = s; q2.push_back(e); end
            4: begin start4 = s; q4.push_back(e); end
            default: begin start1 = s; q1.push_back(e); end
        endcase
    endtask

    // 2x2 CALC run; start asserted in cycle abort_at (negative: none).
    task automatic calc2(input int abort_at);
        for (int k = 0; k < 4; k++) begin
            drive(2, (k == abort_at), ex(1, A2[k], B2[k], S2[k], 1'b1, 1'b1));
            if (k == abort_at) begin
                drive(2, 1'b0, err_e());
                return;
            end
        end
        drive(2, 1'b0, fin_e());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1;
        start2 = 1'b0;
        start4 = 1'b0;
        start1 = 1'b0;
        end_req = 1'b0;

        // Reset holds everything even with start asserted.
        @(posedge clk);
        #1;
        start2 = 1'b1;
        q2.push_back(idle_e()); q4.push_back(idle_e()); q1.push_back(idle_e());
        @(posedge clk);
        #1;
        rst = 1'b0;
        start2 = 1'b0;
        q2.push_back(idle_e()); q4.push_back(idle_e()); q1.push_back(idle_e());
        drive(2, 1'b0, idle_e());

        // Plain 2x2 multiply from IDLE.
        drive(2, 1'b1, acc_idle());
        calc2(-1);
        drive(2, 1'b0, fin_e());

        // Back-to-back restart from FINISH.
        drive(2, 1'b1, acc_fin());
        calc2(-1);

        // Abort in the 2nd CALC cycle, linger in ERR, then restart.
        drive(2, 1'b1, acc_fin());
        calc2(1);
        drive(2, 1'b0, err_e());
        drive(2, 1'b1, acc_err());
        calc2(-1);

        // Abort in the last CALC cycle goes to ERR, not FINISH.
        drive(2, 1'b1, acc_fin());
        calc2(3);
        drive(2, 1'b1, acc_err());
        calc2(-1);

        // Asynchronous reset between edges in the 3rd CALC cycle.
        drive(2, 1'b1, acc_fin());
        drive(2, 1'b0, ex(1, 0, 0, 0, 1'b1, 1'b1));
        drive(2, 1'b0, ex(1, 1, 0, 1, 1'b1, 1'b1));
        @(posedge clk);
        #3;
        rst = 1'b1;
        q2.push_back(idle_e());
        @(posedge clk);
        #1;
        rst = 1'b0;
        q2.push_back(idle_e());
        drive(2, 1'b0, idle_e());
        drive(2, 1'b0, idle_e());

        // 4x2 configuration.
        drive(4, 1'b0, idle_e());
        drive(4, 1'b1, acc_idle());
        for (int k = 0; k < 8; k++) begin
            drive(4, 1'b0, ex(1, A4[k], B4[k], S4[k], 1'b1, 1'b1));
        end
        drive(4, 1'b0, fin_e());
        drive(4, 1'b0, fin_e());

        // 1x1 configuration, twice.
        drive(1, 1'b0, idle_e());
        drive(1, 1'b1, acc_idle());
        drive(1, 1'b0, ex(1, 0, 0, 0, 1'b1, 1'b1));
        drive(1, 1'b0, fin_e());
        drive(1, 1'b1, acc_fin());
        drive(1, 1'b0, ex(1, 0, 0, 0, 1'b1, 1'b1));
        drive(1, 1'b0, fin_e());

        @(posedge clk);
        #1;
        end_req = 1'b1;
    end

endmodule
